// File: rtl/lsu_m.sv
// lsu_m: memory-stage load/store unit for the RV32I cache pipeline.
// Converts the M-stage opcode/funct3/address/store data into one data-cache
// request, stalls the pipeline on `waiting` until the cache answers, and
// returns aligned, extended load data. Misaligned accesses never reach the cache.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   M_in_op/M_in_f3   instr[6:2] and funct3 of the M-stage instruction
//   M_alu_out         effective byte address
//   M_rs2_data        store source data
//   dc_req/dc_we      registered cache request / store flag
//   dc_addr           registered word address
//   dc_strb/dc_wdata  registered byte enables / lane-replicated store data
//   dc_ready/dc_rdata cache completion pulse and read word
//   waiting           pipeline stall
//   M_ld_data         registered extended load result
//   M_misalign        combinational misaligned-access flag
module lsu_m (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  M_in_op,
  input  logic [2:0]  M_in_f3,
  input  logic [31:0] M_alu_out,
  input  logic [31:0] M_rs2_data,
  output logic        dc_req,
  output logic        dc_we,
  output logic [31:0] dc_addr,
  output logic [3:0]  dc_strb,
  output logic [31:0] dc_wdata,
  input  logic        dc_ready,
  input  logic [31:0] dc_rdata,
  output logic        waiting,
  output logic [31:0] M_ld_data,
  output logic        M_misalign
);

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] ld_q, ld_d;

  // instruction decode
  logic is_ld, is_st, mem_op, misal, issue;
  logic [1:0] off;

  assign off   = M_alu_out[1:0];
  assign is_ld = (M_in_op == OP_LOAD) &&
                 (M_in_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign is_st = (M_in_op == OP_STORE) &&
                 (M_in_f3 inside {3'b000, 3'b001, 3'b010});
  assign mem_op = is_ld || is_st;
  // f3[1:0] encodes size for both loads and stores: 00 byte, 01 half, 10 word
  assign misal  = ((M_in_f3[1:0] == 2'b01) && off[0]) ||
                  ((M_in_f3[1:0] == 2'b10) && (off != 2'b00));
  assign issue  = (state_q == IDLE) && mem_op && !misal;

  assign waiting    = rst && (issue || (state_q == ACCESS));
  assign M_misalign = rst && (state_q == IDLE) && mem_op && misal;

  assign dc_req    = req_q;
  assign dc_we     = we_q;
  assign dc_addr   = addr_q;
  assign dc_strb   = strb_q;
  assign dc_wdata  = wdata_q;
  assign M_ld_data = ld_q;

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // next state; DONE always returns to IDLE so the same instruction is
  // not issued twice while the pipeline advances
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = ACCESS;
      ACCESS:  if (dc_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // load extraction from the captured offset/funct3
  logic [31:0] lane, ld_ext;
  always_comb begin
    lane = dc_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_ext = {24'd0, lane[7:0]};
      3'b101:  ld_ext = {16'd0, lane[15:0]};
      default: ld_ext = dc_rdata;
    endcase
  end

  // output / datapath next-state; request fields are held while ACCESS
  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    ld_d    = ld_q;
    case (state_q)
      IDLE: if (issue) begin
        req_d  = 1'b1;
        we_d   = is_st;
        addr_d = {M_alu_out[31:2], 2'b00};
        f3_d   = M_in_f3;
        off_d  = off;
        strb_d  = 4'b0000;
        wdata_d = 32'd0;
        if (is_st) begin
          case (M_in_f3[1:0])
            2'b00: begin
              strb_d  = 4'b0001 << off;
              wdata_d = {4{M_rs2_data[7:0]}};
            end
            2'b01: begin
              strb_d  = 4'b0011 << off;
              wdata_d = {2{M_rs2_data[15:0]}};
            end
            default: begin
              strb_d  = 4'b1111;
              wdata_d = M_rs2_data;
            end
          endcase
        end
      end
      ACCESS: if (dc_ready) begin
        req_d = 1'b0;
        if (!we_q) ld_d = ld_ext;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      strb_q  <= 4'd0;
      wdata_q <= 32'd0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      ld_q    <= 32'd0;
    end else begin
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      ld_q    <= ld_d;
    end
  end

endmodule

// File: tb/tb_lsu_m.sv
module tb_lsu_m;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  M_in_op;
  logic [2:0]  M_in_f3;
  logic [31:0] M_alu_out, M_rs2_data;
  logic        dc_req, dc_we, dc_ready, waiting, M_misalign;
  logic [31:0] dc_addr, dc_wdata, dc_rdata, M_ld_data;
  logic [3:0]  dc_strb;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_ld;

  lsu_m dut (
    .clk(clk), .rst(rst), .M_in_op(M_in_op), .M_in_f3(M_in_f3),
    .M_alu_out(M_alu_out), .M_rs2_data(M_rs2_data),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_strb(dc_strb),
    .dc_wdata(dc_wdata), .dc_ready(dc_ready), .dc_rdata(dc_rdata),
    .waiting(waiting), .M_ld_data(M_ld_data), .M_misalign(M_misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // reference: extended load value from a read word, byte offset and funct3
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                          input logic [2:0] f3);
    logic [31:0] lane;
    lane = w >> (8 * off);
    case (f3)
      3'd0:    return 32'($signed(lane[7:0]));
      3'd1:    return 32'($signed(lane[15:0]));
      3'd4:    return lane & 32'hFF;
      3'd5:    return lane & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  // Runs one M-stage instruction from IDLE; caller is just past a rising edge.
  task automatic run_op(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rs2, input int lat, input logic [31:0] rdata);
    bit ld, st, mem, mis;
    int bytes, wcnt;
    logic [1:0] off;
    logic [3:0] estrb;
    logic [31:0] ewd;
    ld = (op == 5'b00000) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    st = (op == 5'b01000) && (f3 <= 3'd2);
    mem = ld || st;
    bytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mis = (addr % bytes) != 0;
    off = addr[1:0];
    estrb = 4'd0;
    ewd = 32'd0;
    if (st) begin
      estrb = (bytes == 1) ? 4'(1 << off) : (bytes == 2) ? 4'(3 << off) : 4'hF;
      ewd = (bytes == 1) ? rs2[7:0] * 32'h01010101 :
            (bytes == 2) ? rs2[15:0] * 32'h00010001 : rs2;
    end
    M_in_op = op; M_in_f3 = f3; M_alu_out = addr; M_rs2_data = rs2;
    if (!(mem && !mis)) begin
      dc_ready = 1'($urandom);   // stray completion in IDLE must be ignored
      dc_rdata = $urandom;
      #1;
      chk("pass_wait", waiting, 0);
      chk("pass_mis", M_misalign, mem && mis);
      step();
      dc_ready = 1'b0;
      chk("pass_req", dc_req, 0);
      chk("pass_ld", M_ld_data, exp_ld);
      return;
    end
    #1;
    chk("idle_wait", waiting, 1);
    chk("idle_mis", M_misalign, 0);
    wcnt = 1;
    step();
    for (int k = 1; k <= lat; k++) begin
      chk("acc_req", dc_req, 1);
      chk("acc_we", dc_we, st);
      chk("acc_addr", dc_addr, {addr[31:2], 2'b00});
      chk("acc_strb", dc_strb, estrb);
      chk("acc_wdata", dc_wdata, ewd);
      chk("acc_mis", M_misalign, 0);
      if (waiting) wcnt++;
      dc_ready = (k == lat);
      dc_rdata = (k == lat) ? rdata : $urandom;
      step();
      dc_ready = 1'b0;
    end
    if (ld) exp_ld = ref_load(rdata, off, f3);
    chk("done_wait", waiting, 0);
    chk("done_req", dc_req, 0);
    chk("done_ld", M_ld_data, exp_ld);
    chk("wait_cycles", wcnt, lat + 1);
    dc_ready = 1'($urandom);   // stray in DONE
    dc_rdata = $urandom;
    step();
    dc_ready = 1'b0;
    chk("post_ld", M_ld_data, exp_ld);
  endtask

  initial begin
    rst = 1'b0; dc_ready = 1'b0; dc_rdata = 32'd0;
    M_in_op = 5'b00000; M_in_f3 = 3'd2; M_alu_out = 32'h1000; M_rs2_data = 32'd0;
    exp_ld = 32'd0;
    step();
    step();
    chk("rst_req", dc_req, 0);
    chk("rst_we", dc_we, 0);
    chk("rst_addr", dc_addr, 0);
    chk("rst_strb", dc_strb, 0);
    chk("rst_wdata", dc_wdata, 0);
    chk("rst_ld", M_ld_data, 0);
    chk("rst_wait", waiting, 0);
    M_alu_out = 32'h1002; #1;
    chk("rst_mis", M_misalign, 0);
    rst = 1'b1;

    // directed cases
    run_op(5'b00000, 3'd2, 32'h1000, 0, 3, 32'hDEADBEEF);
    chk("lw_const", M_ld_data, 32'hDEADBEEF);
    run_op(5'b00000, 3'd0, 32'h1003, 0, 1, 32'h80FFFFFF);
    chk("lb_const", M_ld_data, 32'hFFFFFF80);
    run_op(5'b00000, 3'd4, 32'h1003, 0, 2, 32'h80FFFFFF);
    chk("lbu_const", M_ld_data, 32'h00000080);
    run_op(5'b00000, 3'd5, 32'h1002, 0, 1, 32'h80010000);
    chk("lhu_const", M_ld_data, 32'h00008001);
    run_op(5'b01000, 3'd0, 32'h2001, 32'h12345678, 2, 0);
    chk("sb_strb", dc_strb, 4'b0010);
    chk("sb_wdata", dc_wdata, 32'h78787878);
    chk("sb_addr", dc_addr, 32'h2000);
    chk("st_keeps_ld", M_ld_data, 32'h00008001);
    run_op(5'b01000, 3'd1, 32'h2002, 32'h12345678, 1, 0);
    chk("sh_strb", dc_strb, 4'b1100);
    chk("sh_wdata", dc_wdata, 32'h56785678);
    run_op(5'b00000, 3'd2, 32'h1002, 0, 1, 0);
    run_op(5'b01000, 3'd1, 32'h2001, 32'hAAAA5555, 1, 0);
    run_op(5'b01100, 3'd0, 32'h0, 0, 1, 0);

    // reset while in ACCESS
    M_in_op = 5'b00000; M_in_f3 = 3'd2; M_alu_out = 32'h3000;
    step();
    chk("racc_req", dc_req, 1);
    rst = 1'b0; #1;
    chk("racc_wait", waiting, 0);
    step();
    chk("racc_req0", dc_req, 0);
    chk("racc_addr", dc_addr, 0);
    dc_ready = 1'b1; dc_rdata = 32'hFFFFFFFF;
    step();
    dc_ready = 1'b0;
    chk("racc_ld", M_ld_data, 0);
    exp_ld = 32'd0;
    rst = 1'b1;
    M_alu_out = 32'h1002; #1;
    chk("racc_idle_mis", M_misalign, 1);
    chk("racc_idle_wait", waiting, 0);
    step();
    chk("racc_noreq", dc_req, 0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [4:0] op;
      int sel;
      sel = $urandom_range(0, 9);
      op = (sel < 5) ? 5'b00000 : (sel < 9) ? 5'b01000 : 5'($urandom);
      run_op(op, 3'($urandom), $urandom, $urandom, $urandom_range(1, 5), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_m.md
# lsu_M

Memory-stage load/store unit of the RV32I cache pipeline, sitting directly upstream of the writeback control register. It turns the M-stage opcode/funct3/address/store-data into a single-request handshake with the data cache, stalls the pipeline through the `waiting` line until the cache answers, and delivers aligned, sign- or zero-extended load data for writeback. Misaligned accesses are flagged and never reach the cache.

## Interface
- No parameters. Data/address width is fixed at 32.
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-low reset
- `M_in_op`  in  5  instr[6:2]; LOAD=5'b00000, STORE=5'b01000, others = non-memory
- `M_in_f3`  in  3  funct3 of M instruction
- `M_alu_out`  in  32  effective byte address
- `M_rs2_data`  in  32  store source
- `dc_req`  out  1  cache request, registered
- `dc_we`  out  1  1 = store, registered
- `dc_addr`  out  32  word address {addr[31:2],2'b00}, registered
- `dc_strb`  out  4  byte enables (stores), registered
- `dc_wdata`  out  32  lane-replicated store data, registered
- `dc_ready`  in  1  cache completion, one-cycle pulse
- `dc_rdata`  in  32  read word, valid with `dc_ready`
- `waiting`  out  1  pipeline stall (feeds writeback control `waiting`)
- `M_ld_data`  out  32  extended load result, registered
- `M_misalign`  out  1  combinational misaligned-access flag

## Operation
- States: IDLE, ACCESS, DONE. Reset state IDLE.
- mem_op = LOAD or STORE with f3 in {000,001,010} (stores) / {000,001,010,100,101} (loads). Other f3: non-memory, no request.
- Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0. `M_misalign`=mem_op && misaligned && state==IDLE; no request, `waiting`=0, instruction passes.
- IDLE: aligned mem_op -> latch addr/we/strb/wdata/f3/offset, set `dc_req`, go ACCESS.
- ACCESS: hold `dc_req` and all dc_* outputs stable. On `dc_ready`: drop `dc_req`, capture load result into `M_ld_data` (loads only), go DONE.
- DONE: one cycle, `waiting`=0 so the pipeline advances; -> IDLE unconditionally (prevents re-issuing the same instruction).
- `waiting` = rst && ((IDLE && aligned mem_op) || ACCESS). Forced 0 while rst low.
- Store formatting: SB wdata={4{rs2[7:0]}}, strb=4'b0001<<off; SH wdata={2{rs2[15:0]}}, strb=4'b0011<<off; SW wdata=rs2, strb=4'b1111. Loads: strb=0, wdata=0.
- Load extraction: lane = dc_rdata >> (8*off). LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW full word.
- `M_ld_data` holds value until next completed load; stores do not alter it.
- `dc_ready` outside ACCESS ignored.

## Timing
- Reset (rst=0 at edge): state IDLE; `dc_req`,`dc_we`=0; `dc_addr`,`dc_strb`,`dc_wdata`,`M_ld_data`=0; `waiting`=0, `M_misalign`=0 during reset.
- Reset mid-ACCESS: next edge returns IDLE, `dc_req` low; pending response ignored.
- Cache latency N cycles after `dc_req` rises (N≥1, `dc_ready` in cycle N): mem instruction occupies M for N+2 cycles; `waiting` high for N+1 of them (IDLE cycle + ACCESS cycles), low in DONE.
- `M_ld_data` valid from DONE cycle onward, i.e. the same edge that advances writeback control captures the instruction one cycle later; it is stable through that writeback cycle.
- Non-memory and misaligned instructions: zero stall, single cycle in IDLE.
- Back-to-back mem ops: second request issues the cycle after DONE.

## Test plan
- Reset: hold rst=0 two cycles with LOAD on inputs -> all outputs 0, `waiting`=0; release -> `dc_req`=1 next edge.
- LW addr 0x1000, dc_ready after 3 cycles with rdata 0xDEADBEEF -> `dc_addr`=0x1000, `waiting` high 4 cycles, `M_ld_data`=0xDEADBEEF in DONE.
- LB addr 0x1003 rdata 0x80FF_FFFF -> 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x1002 rdata 0x8001_0000 -> 0x00008001.
- SB addr 0x2001 rs2=0x12345678 -> `dc_we`=1, `dc_strb`=0010, `dc_wdata`=0x78787878, `dc_addr`=0x2000; SH addr 0x2002 -> strb 1100, wdata 0x56785678.
- LW addr 0x1002 -> `M_misalign`=1, `dc_req` never rises, `waiting`=0; SH addr 0x2001 likewise.
- Assert rst=0 during ACCESS then pulse `dc_ready` -> `dc_req` low, `M_ld_data` unchanged at 0, state IDLE.
